// File: rtl/sign_extend_unit.sv
// Immediate extension unit for decode: a combinational result plus a registered copy with a valid bit.
// Optional macro SEXT_COND_CODE_EN adds a registered {N,Z,P} condition code of the registered result.
module sign_extend_unit #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 I_CLOCK,
   input  logic                 I_RESETN,
   input  logic                 I_LOCK,
   input  logic [IN_WIDTH-1:0]  I_In,
   input  logic [1:0]           I_Mode,
   output logic [OUT_WIDTH-1:0] O_OutComb,
   output logic [OUT_WIDTH-1:0] O_Out,
   output logic                 O_LOCK,
   output logic [2:0]           O_CC
);

   typedef enum logic [1:0] {
      MODE_SEXT  = 2'b00,
      MODE_ZEXT  = 2'b01,
      MODE_HI    = 2'b10,
      MODE_SEXT8 = 2'b11
   } extMode_e;

   logic [OUT_WIDTH-1:0] out_d;
   logic [OUT_WIDTH-1:0] out_q;
   logic                 lock_q;

   always_comb begin
      out_d = '0;
      case (extMode_e'(I_Mode))
         MODE_SEXT:  out_d = {{(OUT_WIDTH-IN_WIDTH){I_In[IN_WIDTH-1]}}, I_In};
         MODE_ZEXT:  out_d = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, I_In};
         MODE_HI:    out_d = {I_In, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
         MODE_SEXT8: out_d = {{(OUT_WIDTH-8){I_In[7]}}, I_In[7:0]};
         default:    out_d = '0;
      endcase
   end

   assign O_OutComb = out_d;

   // Data holds while idle; the valid bit only marks the cycle after an accepted operation.
   always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         out_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         lock_q <= I_LOCK;
         if (I_LOCK) begin
            out_q <= out_d;
         end
      end
   end

   assign O_Out  = out_q;
   assign O_LOCK = lock_q;

`ifdef SEXT_COND_CODE_EN
   logic [2:0] cc_d;
   logic [2:0] cc_q;

   always_comb begin
      cc_d = 3'b001;
      if (out_d[OUT_WIDTH-1]) begin
         cc_d = 3'b100;
      end else if (out_d == '0) begin
         cc_d = 3'b010;
      end
   end

   always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         cc_q <= 3'b000;
      end else if (I_LOCK) begin
         cc_q <= cc_d;
      end
   end

   assign O_CC = cc_q;
`else
   assign O_CC = 3'b000;
`endif

endmodule

// File: tb/tb_sign_extend_unit.sv
// Directed testbench for sign_extend_unit; expected condition codes follow SEXT_COND_CODE_EN when defined.
module tb_sign_extend_unit;

   logic        I_CLOCK;
   logic        I_RESETN;
   logic        I_LOCK;
   logic [15:0] I_In;
   logic [1:0]  I_Mode;
   logic [31:0] O_OutComb;
   logic [31:0] O_Out;
   logic        O_LOCK;
   logic [2:0]  O_CC;

   int testCount;
   int failCount;

   sign_extend_unit #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
      .I_CLOCK   (I_CLOCK),
      .I_RESETN  (I_RESETN),
      .I_LOCK    (I_LOCK),
      .I_In      (I_In),
      .I_Mode    (I_Mode),
      .O_OutComb (O_OutComb),
      .O_Out     (O_Out),
      .O_LOCK    (O_LOCK),
      .O_CC      (O_CC)
   );

   initial I_CLOCK = 1'b0;
   always #5 I_CLOCK = ~I_CLOCK;

   // Expected {N,Z,P} for a result; constant zero when the feature is not built.
   function automatic logic [2:0] expCc(input logic [31:0] value);
`ifdef SEXT_COND_CODE_EN
      if (value[31])
         return 3'b100;
      else if (value == 32'h0)
         return 3'b010;
      else
         return 3'b001;
`else
      return (value == value) ? 3'b000 : 3'b111;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic lock, input logic [1:0] mode, input logic [15:0] value);
      I_LOCK = lock;
      I_Mode = mode;
      I_In   = value;
   endtask

   task automatic stepClock();
      @(posedge I_CLOCK);
      #1;
   endtask

   task automatic checkRegistered(input string tag, input logic [31:0] expOut, input logic expLock, input logic [2:0] ccExp);
      checkOutput({tag, "_out"}, O_Out, expOut);
      checkOutput({tag, "_lock"}, {31'h0, O_LOCK}, {31'h0, expLock});
      checkOutput({tag, "_cc"}, {29'h0, O_CC}, {29'h0, ccExp});
   endtask

   initial begin
      testCount = 0;
      failCount = 0;

      // Reset held with a live-looking operation on the inputs.
      I_RESETN = 1'b0;
      applyStimulus(1'b1, 2'b00, 16'hFFFF);
      stepClock();
      stepClock();
      checkRegistered("reset", 32'h0, 1'b0, 3'b000);
      checkOutput("reset_comb", O_OutComb, 32'hFFFFFFFF);

      I_RESETN = 1'b1;
      applyStimulus(1'b1, 2'b00, 16'h8000);
      #1;
      checkOutput("sext_neg_comb", O_OutComb, 32'hFFFF8000);
      stepClock();
      checkRegistered("sext_neg", 32'hFFFF8000, 1'b1, expCc(32'hFFFF8000));

      applyStimulus(1'b1, 2'b00, 16'h7FFF);
      stepClock();
      checkRegistered("sext_pos", 32'h00007FFF, 1'b1, expCc(32'h00007FFF));

      applyStimulus(1'b1, 2'b01, 16'h8001);
      stepClock();
      checkRegistered("zext", 32'h00008001, 1'b1, expCc(32'h00008001));

      applyStimulus(1'b1, 2'b10, 16'h8001);
      stepClock();
      checkRegistered("hi", 32'h80010000, 1'b1, expCc(32'h80010000));

      applyStimulus(1'b1, 2'b11, 16'h1280);
      stepClock();
      checkRegistered("sext8_neg", 32'hFFFFFF80, 1'b1, expCc(32'hFFFFFF80));

      applyStimulus(1'b1, 2'b11, 16'hAB7F);
      stepClock();
      checkRegistered("sext8_pos", 32'h0000007F, 1'b1, expCc(32'h0000007F));

      // Zero input gives zero in every mode.
      for (int m = 0; m < 4; m++) begin
         applyStimulus(1'b0, m[1:0], 16'h0000);
         #1;
         checkOutput($sformatf("zero_comb_m%0d", m), O_OutComb, 32'h0);
      end

      // Back-to-back accepts, then idle.
      applyStimulus(1'b1, 2'b01, 16'h0001);
      stepClock();
      checkRegistered("b2b_1", 32'h00000001, 1'b1, expCc(32'h00000001));
      applyStimulus(1'b1, 2'b01, 16'h0002);
      stepClock();
      checkRegistered("b2b_2", 32'h00000002, 1'b1, expCc(32'h00000002));
      applyStimulus(1'b1, 2'b01, 16'h0000);
      stepClock();
      checkRegistered("b2b_0", 32'h00000000, 1'b1, expCc(32'h00000000));
      applyStimulus(1'b0, 2'b00, 16'hFFFF);
      stepClock();
      checkRegistered("hold_1", 32'h00000000, 1'b0, expCc(32'h00000000));
      checkOutput("hold_comb", O_OutComb, 32'hFFFFFFFF);
      stepClock();
      checkRegistered("hold_2", 32'h00000000, 1'b0, expCc(32'h00000000));

      // Asynchronous reset between clock edges.
      applyStimulus(1'b1, 2'b00, 16'h1234);
      stepClock();
      checkRegistered("pre_rst", 32'h00001234, 1'b1, expCc(32'h00001234));
      applyStimulus(1'b0, 2'b00, 16'h1234);
      #2;
      I_RESETN = 1'b0;
      #1;
      checkRegistered("async_rst", 32'h0, 1'b0, 3'b000);

      #3;
      I_RESETN = 1'b1;
      applyStimulus(1'b1, 2'b10, 16'h00FF);
      stepClock();
      checkRegistered("after_rst", 32'h00FF0000, 1'b1, expCc(32'h00FF0000));

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/sign_extend_unit.md
Name: sign_extend_unit

Overview:
- Immediate-extension block for the decode stage; widens an IN_WIDTH-bit instruction immediate to an OUT_WIDTH-bit register value.
- Provides a combinational result for same-cycle use by decode logic and a registered copy with a lock/valid bit for the next pipeline stage.
- Supports four extension modes selected per operation.

Parameters:
- IN_WIDTH, 16, immediate width; legal range 8 or more.
- OUT_WIDTH, 32, result width (register width); must be greater than IN_WIDTH.

Ports:
- I_CLOCK  input  1  clock; all state updates on the rising edge.
- I_RESETN  input  1  reset, asynchronous, active-low.
- I_LOCK  input  1  input-valid/enable.
- I_In  input  IN_WIDTH  raw immediate (IR[15:0] in default config).
- I_Mode  input  2  extension mode.
- O_OutComb  output  OUT_WIDTH  combinational extension of I_In/I_Mode.
- O_Out  output  OUT_WIDTH  registered result.
- O_LOCK  output  1  registered valid, aligned with O_Out.
- O_CC  output  3  registered condition code {N,Z,P} of O_Out.

Behaviour:
- Reset (I_RESETN=0, asynchronous assert, synchronous release on the next clock edge): O_Out=0, O_LOCK=0, O_CC=3'b000.
- I_Mode=2'b00 SEXT: OUT = {(OUT_WIDTH-IN_WIDTH){In[IN_WIDTH-1]}, In}.
- I_Mode=2'b01 ZEXT: OUT = {zeros, In}.
- I_Mode=2'b10 HI: In placed in the top IN_WIDTH bits, low OUT_WIDTH-IN_WIDTH bits zero.
- I_Mode=2'b11 SEXT8: sign-extend In[7:0] to OUT_WIDTH. In[IN_WIDTH-1:8] is ignored.
- O_OutComb: pure combinational function of I_In and I_Mode. Zero latency. Independent of I_LOCK, clock and reset.
- Rising edge with I_LOCK=1: O_Out <= O_OutComb, O_LOCK <= 1, O_CC updated. Latency is one cycle.
- Rising edge with I_LOCK=0: O_Out and O_CC hold their values, O_LOCK <= 0.
- No backpressure. A new operation can be accepted every cycle, and each result is valid for exactly the cycle after its I_LOCK=1 edge.
- Boundary cases:
  - In = most-negative value: SEXT gives all ones above bit IN_WIDTH-1.
  - In = 0: every mode gives 0.
  - HI mode never sets the low bits.
- Reset asserted mid-stream clears state immediately. The first accepted operation after release behaves exactly as after power-up.

Optional Feature:
- Macro SEXT_COND_CODE_EN.
- Defined: on each I_LOCK=1 edge, O_CC <= {N,Z,P} of the new result:
  - 3'b100 if MSB=1.
  - 3'b010 if result==0.
  - 3'b001 otherwise.
  - Exactly one bit is set after any accepted operation.
- Not defined: O_CC is constant 3'b000 and no condition-code logic is built.
- Data outputs are identical in both builds.

Test Plan:
- Reset: hold I_RESETN=0 with I_LOCK=1 and I_In=16'hFFFF -> O_Out=0, O_LOCK=0, O_CC=0; O_OutComb=32'hFFFFFFFF.
- SEXT: I_Mode=00; I_In=16'h8000 -> O_Out=32'hFFFF8000 one cycle later; I_In=16'h7FFF -> 32'h00007FFF; O_LOCK=1. With SEXT_COND_CODE_EN, O_CC=100 then 001.
- ZEXT/HI: I_In=16'h8001. Mode 01 -> 32'h00008001. Mode 10 -> 32'h80010000.
- SEXT8: I_Mode=11. I_In=16'h1280 -> 32'hFFFFFF80. I_In=16'hAB7F -> 32'h0000007F.
- Hold and back-to-back: I_LOCK=1 for 3 cycles with values 1, 2, 0 -> O_Out=1, 2, 0 on consecutive cycles, and O_CC=010 after the 0 with the macro. Then I_LOCK=0 -> O_Out stays 0 and O_LOCK falls to 0.
- Async reset mid-stream: assert I_RESETN=0 between clock edges after O_Out=32'h1234 -> O_Out=0 immediately without waiting for a clock edge.
